// File: rtl/led_chk_pkg.sv
// Shared types and WIDTH-generic pattern helpers for the LED chase checker.
// Patterns are handled zero-extended to MAX_W bits, and w gives the real bus width.
package led_chk_pkg;

   typedef enum logic [1:0] {ACQ, TRACK, FAULT} state_t;

   localparam int ERRCNT_W = 8;
   localparam int MAX_W    = 16;

   function automatic logic [MAX_W-1:0] width_mask(input int w);
      logic [MAX_W:0] one_hot;
      one_hot = (MAX_W+1)'(1) << w;
      return MAX_W'(one_hot - 1'b1);
   endfunction

   // Thermometer from bit0: 0, 1, 3, ... all-ones.
   function automatic logic is_fill(input logic [MAX_W-1:0] v, input int w);
      return (v == (v & width_mask(w))) && ((((v + 1'b1) & v)) == '0);
   endfunction

   function automatic logic is_drain(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] m;
      m = width_mask(w);
      return (v == (v & m)) && (v != '0) && (v != m) && is_fill(~v & m, w);
   endfunction

   function automatic logic [MAX_W-1:0] next_pat(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] m;
      m = width_mask(w);
      if (is_fill(v, w) && (v != m))
         return ((v << 1) | 1'b1) & m;
      return (v << 1) & m;
   endfunction

endpackage

// File: rtl/led_chase_checker_step_calc.sv
// Combinational step check: predicts the next bus value and classifies the current sample.
module led_step_calc
   import led_chk_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           prev_q,
   input  logic                       prev_en,
   input  logic [WIDTH-1:0]           q,
   output logic [WIDTH-1:0]           expected,
   output logic                       match,
   output logic                       q_legal,
   output logic                       is_wrap,
   output logic [$clog2(WIDTH+1)-1:0] popcount
);
   localparam int LVL_W = $clog2(WIDTH+1);
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   logic [MAX_W-1:0] prev_ext;
   logic [MAX_W-1:0] q_ext;
   logic [LVL_W-1:0] psum [0:WIDTH];

   assign prev_ext = MAX_W'(prev_q);
   assign q_ext    = MAX_W'(q);

   assign expected = prev_en ? WIDTH'(next_pat(prev_ext, WIDTH)) : prev_q;
   assign match    = (q == expected);
   assign q_legal  = is_fill(q_ext, WIDTH) || is_drain(q_ext, WIDTH);
   // Only the enabled MSB-only -> 0 step closes a fill+drain cycle.
   assign is_wrap  = match && prev_en && (prev_q == MSB_ONLY);

   assign psum[0] = '0;
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pop
         assign psum[gi+1] = psum[gi] + LVL_W'(q[gi]);
      end
   endgenerate
   assign popcount = psum[WIDTH];

endmodule

// File: rtl/led_chase_checker.sv
// Receive-side monitor for the fill/drain LED chase bus: locks on, tracks, flags faults.
// Optional LED_CHK_ERRCNT_EN adds a saturating err_count and makes faults recoverable.
module led_chase_checker
   import led_chk_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [WIDTH-1:0]           q,
   output logic                       locked,
   output logic                       phase,
   output logic [$clog2(WIDTH+1)-1:0] level,
   output logic                       err,
   output logic [CNT_W-1:0]           cycles
`ifdef LED_CHK_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0]        err_count
`endif
);
   localparam int LVL_W = $clog2(WIDTH+1);

   state_t           state_reg;
   logic [WIDTH-1:0] prev_q_reg;
   logic             prev_en_reg;

   logic [WIDTH-1:0] expected;
   logic             match;
   logic             q_legal;
   logic             is_wrap;
   logic [LVL_W-1:0] popcount;
   logic             q_phase;
   logic             accept;
   logic             fault_now;

   led_step_calc #(.WIDTH(WIDTH)) u_step (
      .prev_q   (prev_q_reg),
      .prev_en  (prev_en_reg),
      .q        (q),
      .expected (expected),
      .match    (match),
      .q_legal  (q_legal),
      .is_wrap  (is_wrap),
      .popcount (popcount)
   );

   assign q_phase   = (q == '1) || is_drain(MAX_W'(q), WIDTH);
   assign accept    = ((state_reg == ACQ) && q_legal) || ((state_reg == TRACK) && match);
   assign fault_now = ((state_reg == ACQ) && !q_legal) || ((state_reg == TRACK) && !match);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ACQ;
         prev_q_reg  <= '0;
         prev_en_reg <= 1'b0;
         locked      <= 1'b0;
         phase       <= 1'b0;
         level       <= '0;
         err         <= 1'b0;
         cycles      <= '0;
`ifdef LED_CHK_ERRCNT_EN
         err_count   <= '0;
`endif
      end else if (accept) begin
         state_reg   <= TRACK;
         prev_q_reg  <= (state_reg == TRACK) ? expected : q;
         prev_en_reg <= enable;
         locked      <= 1'b1;
         level       <= popcount;
         phase       <= q_phase;
         if ((state_reg == TRACK) && is_wrap)
            cycles <= cycles + 1'b1;
      end else if (fault_now) begin
         state_reg <= FAULT;
         locked    <= 1'b0;
         err       <= 1'b1;
`ifdef LED_CHK_ERRCNT_EN
         if (err_count != '1)
            err_count <= err_count + 1'b1;
`endif
      end else if (state_reg == FAULT) begin
`ifdef LED_CHK_ERRCNT_EN
         state_reg <= ACQ;
`else
         state_reg <= FAULT;
`endif
      end
   end

endmodule

// File: tb/tb_led_chase_checker.sv
// Randomised scoreboard bench for led_chase_checker against a sequence-index reference model.
module tb_led_chase_checker;
   localparam int W = 8;
   localparam int L = 2 * W;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [W-1:0] q;

   logic         locked, phase, err;
   logic [3:0]   level;
   logic [15:0]  cycles;
   logic [7:0]   err_count;
   logic         locked2, phase2, err2;
   logic [3:0]   level2;
   logic [1:0]   cycles2;
   logic [7:0]   err_count2;

   int checks = 0;
   int errors = 0;

   // reference model: position in the 2W-long fill/drain sequence
   int m_mode;
   int m_idx;
   bit m_en;
   bit m_locked, m_phase, m_err;
   int m_level, m_cycles, m_errcnt;

   int g_idx;
   bit g_en;

   always #10 clk = ~clk;

   led_chase_checker #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .q(q),
      .locked(locked), .phase(phase), .level(level), .err(err), .cycles(cycles)
`ifdef LED_CHK_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   led_chase_checker #(.WIDTH(W), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .q(q),
      .locked(locked2), .phase(phase2), .level(level2), .err(err2), .cycles(cycles2)
`ifdef LED_CHK_ERRCNT_EN
      , .err_count(err_count2)
`endif
   );

`ifndef LED_CHK_ERRCNT_EN
   assign err_count  = '0;
   assign err_count2 = '0;
`endif

   function automatic logic [W-1:0] pat(input int idx);
      logic [W-1:0] ones;
      ones = '1;
      if (idx <= W)
         return W'((1 << idx) - 1);
      return ones << (idx - W);
   endfunction

   function automatic int find(input logic [W-1:0] v);
      for (int i = 0; i < L; i++)
         if (pat(i) == v) return i;
      return -1;
   endfunction

   function automatic logic [47:0] obs();
      return {locked, phase, level, err, cycles, err_count,
              locked2, phase2, level2, err2, cycles2, err_count2};
   endfunction

   function automatic logic [47:0] exp_vec();
      return {m_locked, m_phase, 4'(m_level), m_err, 16'(m_cycles), 8'(m_errcnt),
              m_locked, m_phase, 4'(m_level), m_err, 2'(m_cycles), 8'(m_errcnt)};
   endfunction

   task automatic model_accept(input int i, input bit ev);
      m_mode   = 1;
      m_idx    = i;
      m_en     = ev;
      m_locked = 1'b1;
      m_level  = (i <= W) ? i : L - i;
      m_phase  = (i >= W);
   endtask

   task automatic model_fault();
      m_mode   = 2;
      m_locked = 1'b0;
      m_err    = 1'b1;
`ifdef LED_CHK_ERRCNT_EN
      if (m_errcnt < 255) m_errcnt++;
`endif
   endtask

   task automatic model_step(input logic [W-1:0] qv, input bit ev, input bit rv);
      int i;
      i = find(qv);
      if (rv) begin
         m_mode = 0; m_idx = 0; m_en = 0; m_locked = 0; m_phase = 0;
         m_level = 0; m_err = 0; m_cycles = 0; m_errcnt = 0;
      end else if (m_mode == 0) begin
         if (i >= 0) model_accept(i, ev);
         else model_fault();
      end else if (m_mode == 1) begin
         if (i == (m_idx + int'(m_en)) % L) begin
            if (m_en && m_idx == L - 1) m_cycles++;
            model_accept(i, ev);
         end else begin
            model_fault();
         end
      end else begin
`ifdef LED_CHK_ERRCNT_EN
         m_mode = 0;
`endif
      end
   endtask

   task automatic tick(input logic [W-1:0] qv, input bit ev, input bit rv);
      @(negedge clk);
      q = qv; enable = ev; reset = rv;
      @(posedge clk);
      model_step(qv, ev, rv);
      #1;
   endtask

   task automatic gen_tick();
      tick(pat(g_idx), g_en, 1'b0);
      if (g_en) g_idx = (g_idx + 1) % L;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 5; c++) begin
         tick(W'($urandom), 1'($urandom), 1'b1);
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL reset c=%0d got=%h want=%h", c, obs(), exp_vec());
         end
      end
      $display("test_reset: outputs cleared over 5 reset cycles");
   endtask

   task automatic test_chase();
      tick('0, 1'b0, 1'b1);
      g_idx = 0;
      for (int c = 0; c < 200; c++) begin
         g_en = ((c / 5) % 2) == 0;
         gen_tick();
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL chase c=%0d q=%h got=%h want=%h", c, q, obs(), exp_vec());
         end
      end
      checks++;
      if (err !== 1'b0 || cycles !== 16'd6) begin
         errors++;
         $display("FAIL chase_end err=%b cycles=%0d want err=0 cycles=6", err, cycles);
      end
      $display("test_chase: 200 cycles, cycles=%0d", cycles);
   endtask

   task automatic test_hold_violation();
      tick('0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) tick(8'h0F, 1'b0, 1'b0);
      tick(8'h1F, 1'b0, 1'b0);
      checks++;
      if (err !== 1'b1 || locked !== 1'b0 || level !== 4'd4 || obs() !== exp_vec()) begin
         errors++;
         $display("FAIL hold_violation err=%b locked=%b level=%0d want 1 0 4", err, locked, level);
      end
      $display("test_hold_violation: q changed with enable low");
   endtask

   task automatic test_double_step();
      tick('0, 1'b0, 1'b1);
      tick(8'h03, 1'b1, 1'b0);
      tick(8'h0F, 1'b1, 1'b0);
      checks++;
      if (err !== 1'b1 || locked !== 1'b0 || obs() !== exp_vec()) begin
         errors++;
         $display("FAIL double_step err=%b locked=%b want err=1 locked=0", err, locked);
      end
      g_idx = 5; g_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         gen_tick();
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL relock c=%0d got=%h want=%h", c, obs(), exp_vec());
         end
      end
`ifdef LED_CHK_ERRCNT_EN
      checks++;
      if (err_count !== 8'd1 || locked !== 1'b1) begin
         errors++;
         $display("FAIL errcnt_relock err_count=%0d locked=%b want 1 1", err_count, locked);
      end
`endif
      $display("test_double_step: skipped value detected");
   endtask

   task automatic test_illegal_start();
      tick('0, 1'b0, 1'b1);
      tick(8'h55, 1'b1, 1'b0);
      checks++;
      if (err !== 1'b1 || cycles !== 16'd0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL illegal_start err=%b cycles=%0d locked=%b want 1 0 0", err, cycles, locked);
      end
      $display("test_illegal_start: 0x55 rejected in acquisition");
   endtask

   task automatic test_reset_mid();
      tick('0, 1'b0, 1'b1);
      g_idx = 0; g_en = 1'b1;
      for (int c = 0; c < 7; c++) gen_tick();
      checks++;
      if (level !== 4'd6 || obs() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_mid_pre level=%0d want 6", level);
      end
      tick(pat(g_idx), 1'b1, 1'b1);
      checks++;
      if (obs() !== 48'd0) begin
         errors++;
         $display("FAIL reset_mid got=%h want=0", obs());
      end
      for (int c = 0; c < 3; c++) begin
         gen_tick();
         checks++;
         if (locked !== 1'b1 || obs() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_relock c=%0d got=%h want=%h", c, obs(), exp_vec());
         end
      end
      $display("test_reset_mid: history discarded, re-locked");
   endtask

   task automatic test_wrap();
      tick('0, 1'b0, 1'b1);
      g_idx = 0; g_en = 1'b1;
      for (int c = 0; c < 5 * L + 1; c++) gen_tick();
      checks++;
      if (cycles2 !== 2'd1 || cycles !== 16'd5 || err !== 1'b0 || obs() !== exp_vec()) begin
         errors++;
         $display("FAIL wrap cycles2=%0d cycles=%0d err=%b want 1 5 0", cycles2, cycles, err);
      end
      $display("test_wrap: 5 full cycles, 2-bit counter=%0d", cycles2);
   endtask

   task automatic test_random();
      bit rv;
      logic [W-1:0] qv;
      tick('0, 1'b0, 1'b1);
      for (int c = 0; c < 400; c++) begin
         g_en = 1'($urandom_range(0, 1));
         rv   = ($urandom_range(0, 49) == 0);
         qv   = ($urandom_range(0, 39) == 0) ? W'($urandom) : pat(g_idx);
         tick(qv, g_en, rv);
         if (!rv && g_en) g_idx = (g_idx + 1) % L;
         checks++;
         if (obs() !== exp_vec()) begin
            errors++;
            $display("FAIL random c=%0d q=%h en=%b got=%h want=%h", c, qv, g_en, obs(), exp_vec());
         end
      end
      $display("test_random: 400 randomised cycles");
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; q = '0;
      g_idx = 0; g_en = 1'b0;
      model_step('0, 1'b0, 1'b1);
      test_reset();
      test_chase();
      test_hold_violation();
      test_double_step();
      test_illegal_start();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
